// File: rtl/tensor_pkg.sv
// ----------------------------------------------------------------------------
// tensor_pkg
// Shared definitions for the tensor-core operand loader.
//   TILE_DIM        matrix dimension of one operand tile (8x8)
//   ROW_IDX_W       width of a row/column index within a tile
//   loader_state_e  loader FSM states
// Row and tile typedefs depend on DATA_WIDTH, so each user declares them
// locally from its own parameter.
// ----------------------------------------------------------------------------
package tensor_pkg;

    localparam int TILE_DIM  = 8;
    localparam int ROW_IDX_W = $clog2(TILE_DIM);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } loader_state_e;

endpackage

// File: rtl/tensor_tile_reg.sv
// ----------------------------------------------------------------------------
// tensor_tile_reg
// 8x8 register array holding one operand tile.
//   clk       clock, all writes on posedge
//   rst_n     asynchronous active-low reset, clears every element to 0
//   i_row_we  write i_data as row i_idx: element k -> tile[i_idx][k]
//   i_col_we  write i_data as column i_idx: element k -> tile[k][i_idx]
//   i_idx     row or column index being written
//   i_data    one beat; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   o_tile    registered tile, [row][col]
// Contents are held whenever neither write enable is asserted.
// ----------------------------------------------------------------------------
module tensor_tile_reg
    import tensor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)(
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            i_row_we,
    input  logic                                            i_col_we,
    input  logic [ROW_IDX_W-1:0]                            i_idx,
    input  logic [TILE_DIM*DATA_WIDTH-1:0]                  i_data,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] o_tile
);

    typedef logic [TILE_DIM-1:0][DATA_WIDTH-1:0] row_t;
    typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] tile_t;

    row_t  w_row;
    tile_t r_tile;

    // Packed element k lands exactly on bits [k*DATA_WIDTH +: DATA_WIDTH].
    assign w_row = i_data;

    // NOTE: this array is flops, not RAM, so it can and must take the async
    // reset; a true memory macro could not be cleared this way.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile <= '0;
        end else if (i_row_we) begin
            r_tile[i_idx] <= w_row;
        end else if (i_col_we) begin
            for (int k = 0; k < TILE_DIM; k++) begin
                r_tile[k][i_idx] <= w_row[k];
            end
        end
    end

    assign o_tile = r_tile;

endmodule

// File: rtl/tensor_tile_loader.sv
// ----------------------------------------------------------------------------
// tensor_tile_loader
// Collects row-serial operand beats into registered 8x8 A and B tiles and
// presents them to the tensor core with a valid/ready handshake.
//   clk         clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous abort of a partially loaded tile
//   in_valid    operand beat valid
//   in_ready    loader can accept a beat
//   in_row      one beat; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   tile_valid  tile_a/tile_b complete and stable
//   tile_ready  consumer takes the tile
//   tile_a      matrix A, [row][col]
//   tile_b      matrix B, [row][col]
//   tile_count  tiles handed off, wraps at 2**CNT_WIDTH
// Build option: define TENSOR_LOADER_TRANSPOSE_B_EN to treat each B beat as a
// column (element k -> tile_b[k][c]) for column-major B storage.
// ----------------------------------------------------------------------------
module tensor_tile_loader
    import tensor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
)(
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            flush,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [TILE_DIM*DATA_WIDTH-1:0]                  in_row,
    output logic                                            tile_valid,
    input  logic                                            tile_ready,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] tile_a,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] tile_b,
    output logic [CNT_WIDTH-1:0]                            tile_count
);

    loader_state_e         r_state;
    loader_state_e         w_next_state;
    logic [ROW_IDX_W-1:0]  r_row;
    logic [CNT_WIDTH-1:0]  r_tile_count;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_handoff;
    logic                  w_a_we;
    logic                  w_b_we;
    logic                  w_b_row_we;
    logic                  w_b_col_we;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: defaulting every combinational output first keeps the block
    // latch-free even where a branch leaves it unassigned.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A:  if (w_accept && w_last_beat) w_next_state = LOAD_B;
                LOAD_B:  if (w_accept && w_last_beat) w_next_state = PRESENT;
                PRESENT: if (tile_ready)              w_next_state = LOAD_A;
                default:                              w_next_state = LOAD_A;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready   = (r_state != PRESENT) && !flush;
        tile_valid = (r_state == PRESENT);
        w_a_we     = 1'b0;
        w_b_we     = 1'b0;
        if (in_valid && in_ready) begin
            w_a_we = (r_state == LOAD_A);
            w_b_we = (r_state == LOAD_B);
        end
    end

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_row == ROW_IDX_W'(TILE_DIM - 1));
    // flush in PRESENT withdraws the tile without counting it.
    assign w_handoff   = tile_valid && tile_ready && !flush;

`ifdef TENSOR_LOADER_TRANSPOSE_B_EN
    assign w_b_row_we = 1'b0;
    assign w_b_col_we = w_b_we;
`else
    assign w_b_row_we = w_b_we;
    assign w_b_col_we = 1'b0;
`endif

    // Row counter wraps 7 -> 0 on its own, which lines up with the
    // LOAD_A -> LOAD_B and LOAD_B -> PRESENT transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
        end else if (flush) begin
            r_row <= '0;
        end else if (w_accept) begin
            r_row <= r_row + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile_count <= '0;
        end else if (w_handoff) begin
            r_tile_count <= r_tile_count + 1'b1;
        end
    end

    assign tile_count = r_tile_count;

    tensor_tile_reg #(.DATA_WIDTH(DATA_WIDTH)) u_tile_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_row_we (w_a_we),
        .i_col_we (1'b0),
        .i_idx    (r_row),
        .i_data   (in_row),
        .o_tile   (tile_a)
    );

    tensor_tile_reg #(.DATA_WIDTH(DATA_WIDTH)) u_tile_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_row_we (w_b_row_we),
        .i_col_we (w_b_col_we),
        .i_idx    (r_row),
        .i_data   (in_row),
        .o_tile   (tile_b)
    );

endmodule

// File: tb/tb_tensor_tile_loader.sv
// ----------------------------------------------------------------------------
// tb_tensor_tile_loader
// Directed bench for tensor_tile_loader. Beats are driven and sampled on the
// falling clock edge; the expected tiles for each complete load are pushed to
// a scoreboard and popped at handoff. Honours TENSOR_LOADER_TRANSPOSE_B_EN.
// ----------------------------------------------------------------------------
module tb_tensor_tile_loader;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int DIM = 8;

    typedef logic [DIM*DW-1:0]               beat_t;
    typedef logic [DIM-1:0][DIM-1:0][DW-1:0] tile_t;
    typedef struct packed {
        tile_t a;
        tile_t b;
    } pair_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    beat_t         in_row;
    logic          tile_valid;
    logic          tile_ready;
    tile_t         tile_a;
    tile_t         tile_b;
    logic [CW-1:0] tile_count;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_count = '0;
    beat_t         beats [16];
    pair_t         sb [$];

    tensor_tile_loader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_a     (tile_a),
        .tile_b     (tile_b),
        .tile_count (tile_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tile(input string tag, input tile_t obs, input tile_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (obs[r][c] !== exp[r][c]) begin
                        $error("FAIL %s: [%0d][%0d] observed %0h expected %0h",
                               tag, r, c, obs[r][c], exp[r][c]);
                        return;
                    end
                end
            end
        end
    endtask

    // Drive beats[first .. first+n-1]; gap_pct is the chance of an idle cycle.
    task automatic drive_beats(input int first, input int n, input int gap_pct,
                               output int cycles);
        int idx = first;
        bit acc;
        cycles = 0;
        while (idx < first + n) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_row   = beats[idx];
            #1;
            check("in_ready_load", in_ready, 1'b1);
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            cycles++;
            if (cycles > 2000) begin
                check("drive_timeout", 1'b0, 1'b1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Full 16-beat load; the expected tiles follow directly from the beats.
    task automatic load_tile(input int gap_pct, output int cycles);
        pair_t p;
        drive_beats(0, 16, gap_pct, cycles);
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                p.a[r][k] = beats[r][k*DW +: DW];
`ifdef TENSOR_LOADER_TRANSPOSE_B_EN
                p.b[k][r] = beats[8+r][k*DW +: DW];
`else
                p.b[r][k] = beats[8+r][k*DW +: DW];
`endif
            end
        end
        sb.push_back(p);
    endtask

    task automatic handoff();
        pair_t p;
        int    budget = 0;
        while (!tile_valid && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("handoff_wait", tile_valid, 1'b1);
        tile_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_nonempty", 1'b0, 1'b1);
        end else begin
            p = sb.pop_front();
            check_tile("handoff_tile_a", tile_a, p.a);
            check_tile("handoff_tile_b", tile_b, p.b);
        end
        exp_count++;
        @(negedge clk);
        tile_ready = 1'b0;
        check("valid_after_handoff", tile_valid, 1'b0);
        check("tile_count", tile_count, exp_count);
        check("in_ready_after_handoff", in_ready, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exp_count = '0;
        sb.delete();
    endtask

    task automatic fill_a_seq();
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++)
                beats[r][k*DW +: DW] = DW'(r*8 + k);
    endtask

    task automatic fill_b_identity();
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++)
                beats[8+r][k*DW +: DW] = (r == k) ? DW'(1) : DW'(0);
    endtask

    task automatic fill_random(input int first, input int n);
        for (int i = first; i < first + n; i++)
            for (int k = 0; k < DIM; k++)
                beats[i][k*DW +: DW] = $urandom();
    endtask

    initial begin
        int    cyc;
        tile_t held_a;
        tile_t held_b;

        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_row     = '0;
        tile_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values.
        check("rst_tile_valid", tile_valid, 1'b0);
        check("rst_tile_count", tile_count, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check_tile("rst_tile_a", tile_a, '0);
        check_tile("rst_tile_b", tile_b, '0);

        // Back-to-back load: A = r*8+k, B = identity.
        fill_a_seq();
        fill_b_identity();
        load_tile(0, cyc);
        check("load_cycles", cyc, 16);
        check("valid_cycle17", tile_valid, 1'b1);
        check("tile_a_3_5", tile_a[3][5], 29);
        for (int i = 0; i < DIM; i++) check("tile_b_diag", tile_b[i][i], 1);
        handoff();

        // Gapped load, consumer stalls 10 cycles in PRESENT.
        do_reset();
        fill_random(0, 16);
        load_tile(50, cyc);
        check("valid_after_gapped", tile_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_row   = {DIM{32'hDEAD_BEEF}};
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_valid", tile_valid, 1'b1);
            check_tile("stall_tile_a", tile_a, sb[0].a);
            check_tile("stall_tile_b", tile_b, sb[0].b);
            @(negedge clk);
        end
        in_valid = 1'b0;
        handoff();

        // flush after 5 A beats, then a fresh tile with A all 7.
        fill_random(0, 16);
        drive_beats(0, 5, 0, cyc);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_row   = {DIM{32'h5555_5555}};
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int r = 0; r < DIM; r++) beats[r] = {DIM{32'd7}};
        fill_random(8, 8);
        load_tile(0, cyc);
        check("flush_reload_cycles", cyc, 16);
        handoff();

        // flush together with tile_ready in PRESENT.
        fill_random(0, 16);
        load_tile(0, cyc);
        check("pre_flush_valid", tile_valid, 1'b1);
        held_a     = sb[0].a;
        held_b     = sb[0].b;
        flush      = 1'b1;
        tile_ready = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        tile_ready = 1'b0;
        void'(sb.pop_front());
        check("flush_present_valid", tile_valid, 1'b0);
        check("flush_present_count", tile_count, exp_count);
        check_tile("flush_retain_a", tile_a, held_a);
        check_tile("flush_retain_b", tile_b, held_b);
        @(negedge clk);
        check("flush_present_valid2", tile_valid, 1'b0);
        check("flush_present_ready", in_ready, 1'b1);

        // Asynchronous reset mid-LOAD_B.
        fill_random(0, 16);
        drive_beats(0, 10, 0, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tile_valid", tile_valid, 1'b0);
        check("arst_tile_count", tile_count, '0);
        check_tile("arst_tile_a", tile_a, '0);
        check_tile("arst_tile_b", tile_b, '0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = '0;
        sb.delete();
        fill_random(0, 16);
        load_tile(0, cyc);
        check("arst_reload_cycles", cyc, 16);
        handoff();

        // B beat c = {c*8+k}: row or column interpretation.
        fill_a_seq();
        for (int r = 0; r < DIM; r++) beats[8+r] = beats[r];
        load_tile(0, cyc);
`ifdef TENSOR_LOADER_TRANSPOSE_B_EN
        check("tile_b_2_6", tile_b[2][6], 50);
`else
        check("tile_b_2_6", tile_b[2][6], 22);
`endif
        handoff();

        // tile_ready outside PRESENT must not count.
        tile_ready = 1'b1;
        repeat (3) @(negedge clk);
        tile_ready = 1'b0;
        check("ready_idle_count", tile_count, exp_count);
        check("ready_idle_valid", tile_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
